// File: rtl/dmem_bridge.sv
// MEM-stage to single-port data bus bridge: sizes, aligns and sequences loads/stores,
// stalling the pipeline until each access completes, errors out or times out.
module dmem_bridge #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [2:0]        mem_funct3,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic              mem_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT_R = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       lat_f3;
    logic [1:0]       lat_off;
    logic             req_any;
    logic             req_bad;
    logic             cnt_last;

    // Misaligned halves/words and the unused funct3 codes all fail without a bus cycle.
    function automatic logic access_bad(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = off[0];
            3'b010:         bad = (off != 2'b00);
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign req_any  = mem_read | mem_write;
    assign req_bad  = access_bad(mem_funct3, mem_addr[1:0]);
    assign cnt_last = (cnt == CNT_LAST);
    assign bus_req  = (state == S_REQ);
    assign mem_stall = ~reset & (((state == S_IDLE) & req_any) |
                                 (state == S_REQ) | (state == S_WAIT_R));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_f3    <= 3'b000;
            lat_off   <= 2'b00;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= '0;
            mem_rdata <= '0;
            mem_err   <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        if (req_bad) begin
                            state   <= S_DONE;
                            mem_err <= 1'b1;
                            if (!mem_write) mem_rdata <= '0;
                        end else begin
                            // Write wins when both strobes are high.
                            state     <= S_REQ;
                            cnt       <= '0;
                            bus_we    <= mem_write;
                            bus_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
                            bus_be    <= lane_be(mem_funct3[1:0], mem_addr[1:0]);
                            bus_wdata <= lane_data(mem_funct3[1:0], mem_wdata);
                            lat_f3    <= mem_funct3;
                            lat_off   <= mem_addr[1:0];
                        end
                    end
                end
                S_REQ: begin
                    if (bus_gnt) begin
                        state <= bus_we ? S_DONE : S_WAIT_R;
                        cnt   <= '0;
                    end else if (cnt_last) begin
                        state   <= S_DONE;
                        mem_err <= 1'b1;
                        if (!bus_we) mem_rdata <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_R: begin
                    if (bus_rvalid) begin
                        state     <= S_DONE;
                        mem_rdata <= load_extract(lat_f3, lat_off, bus_rdata);
                    end else if (cnt_last) begin
                        state     <= S_DONE;
                        mem_err   <= 1'b1;
                        mem_rdata <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: a transaction-level model predicts stall length,
// error flag, load data and bus fields; a per-cycle process checks the bus side.
module tb_dmem_bridge;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [2:0]    mem_funct3;
    logic [31:0]   mem_rdata;
    logic          mem_stall, mem_err;
    logic          bus_req, bus_we;
    logic [AW-1:0] bus_addr;
    logic [3:0]    bus_be;
    logic [31:0]   bus_wdata;
    logic          bus_gnt, bus_rvalid;
    logic [31:0]   bus_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic          exp_bus_ok;
    logic [AW-1:0] exp_addr;
    logic          exp_we;
    logic [3:0]    exp_be;
    logic [31:0]   exp_wdata;
    logic [31:0]   model_rdata;

    logic          saw_req;
    logic [AW-1:0] snap_addr;
    logic          snap_we;
    logic [3:0]    snap_be;
    logic [31:0]   snap_wdata;

    int          st;
    logic        er;
    logic [31:0] rd;

    dmem_bridge #(.ADDR_W(AW), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
        .mem_stall(mem_stall), .mem_err(mem_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic model_bad(input logic [2:0] f3, input logic [AW-1:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) return a[0];
        if (f3 == 3'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [AW-1:0] a);
        int k;
        k = a % 4;
        if (f3 == 3'd0 || f3 == 3'd4) return 4'(1 << k);
        if (f3 == 3'd1 || f3 == 3'd5) return (k >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0 || f3 == 3'd4) return (d & 32'hFF) * 32'h01010101;
        if (f3 == 3'd1 || f3 == 3'd5) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [AW-1:0] a,
                                               input logic [31:0] w);
        logic [31:0] v;
        int k;
        k = a % 4;
        v = w;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (w >> (8 * k)) & 32'hFF;
            if (f3 == 3'd0 && v >= 128) v = v - 256;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            v = (w >> (16 * (k / 2))) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    task automatic set_expect(input logic wr, input logic [AW-1:0] a, input logic [2:0] f3,
                              input logic [31:0] wd);
        exp_bus_ok = !model_bad(f3, a);
        exp_addr   = a & ~AW'(3);
        exp_we     = wr;
        exp_be     = model_be(f3, a);
        exp_wdata  = model_wdata(f3, wd);
    endtask

    // Called just after a rising edge with the DUT idle; returns just after the edge leaving DONE.
    task automatic run(input logic r, input logic w, input logic [AW-1:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, input logic [31:0] word, input int gnt_at,
                       input int rv_at, output int stall_n, output logic err_s,
                       output logic [31:0] rdata_s);
        logic bad, tmo_req, tmo_rd, granted, done;
        int exp_stall, req_n, wait_n, cyc;
        bad     = model_bad(f3, a);
        tmo_req = !bad && (gnt_at < 1 || gnt_at > 16);
        tmo_rd  = !bad && !tmo_req && !w && (rv_at < 1 || rv_at > 16);
        if (bad)          exp_stall = 1;
        else if (tmo_req) exp_stall = 17;
        else if (w)       exp_stall = 1 + gnt_at;
        else if (tmo_rd)  exp_stall = 1 + gnt_at + 16;
        else              exp_stall = 1 + gnt_at + rv_at;
        if (!w) model_rdata = (bad || tmo_req || tmo_rd) ? 32'd0 : model_load(f3, a, word);
        set_expect(w, a, f3, wd);
        saw_req = 1'b0;
        mem_read = r; mem_write = w; mem_addr = a; mem_funct3 = f3; mem_wdata = wd;
        req_n = 0; wait_n = 0; cyc = 0; granted = 1'b0; done = 1'b0;
        stall_n = 0; err_s = 1'b0; rdata_s = 32'd0;
        while (!done && cyc < 60) begin
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'hA5A5A5A5;
            if (bus_req) begin
                req_n++;
                if (req_n == gnt_at) begin bus_gnt = 1'b1; granted = 1'b1; end
            end else if (granted && !w) begin
                wait_n++;
                if (wait_n == rv_at) begin bus_rvalid = 1'b1; bus_rdata = word; end
            end
            @(negedge clk);
            if (mem_stall) stall_n++;
            else begin done = 1'b1; err_s = mem_err; rdata_s = mem_rdata; end
            @(posedge clk); #1;
            cyc++;
        end
        mem_read = 1'b0; mem_write = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        check("access_completes", {31'd0, done}, 32'd1);
        check("stall_cycles", stall_n, exp_stall);
        check("done_err", {31'd0, err_s}, {31'd0, bad || tmo_req || tmo_rd});
        check("done_rdata", rdata_s, model_rdata);
        check("err_cleared_after_done", {31'd0, mem_err}, 32'd0);
    endtask

    // Bus-side checks on every cycle the request is up.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (bus_req) begin
                saw_req = 1'b1;
                snap_addr = bus_addr; snap_we = bus_we; snap_be = bus_be; snap_wdata = bus_wdata;
                check("bus_req_allowed", {31'd0, exp_bus_ok}, 32'd1);
                check("bus_addr", {23'd0, bus_addr}, {23'd0, exp_addr});
                check("bus_we", {31'd0, bus_we}, {31'd0, exp_we});
                check("bus_be", {28'd0, bus_be}, {28'd0, exp_be});
                check("bus_wdata", bus_wdata, exp_wdata);
            end
            if (mem_stall) check("err_low_while_stalled", {31'd0, mem_err}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        mem_funct3 = 3'd2; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        model_rdata = '0; saw_req = 1'b0;
        snap_addr = '0; snap_we = 1'b0; snap_be = '0; snap_wdata = '0;
        set_expect(1'b0, '0, 3'd2, 32'd0);
        #12;
        check("reset_bus_req", {31'd0, bus_req}, 32'd0);
        check("reset_stall", {31'd0, mem_stall}, 32'd0);
        check("reset_outputs", {bus_we, mem_err, bus_be, 3'd0, bus_addr, 14'd0}, 32'd0);
        check("reset_wdata", bus_wdata, 32'd0);
        check("reset_rdata", mem_rdata, 32'd0);
        mem_read = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        run(1'b0, 1'b1, 9'h010, 3'd2, 32'hDEADBEEF, 32'd0, 1, 0, st, er, rd);
        check("sw_be_lit", {28'd0, snap_be}, 32'h0000000F);
        check("sw_addr_lit", {23'd0, snap_addr}, 32'h00000010);
        check("sw_we_lit", {31'd0, snap_we}, 32'd1);
        check("sw_stall_lit", st, 32'd2);

        run(1'b1, 1'b0, 9'h013, 3'd0, 32'd0, 32'h80FF7F01, 1, 2, st, er, rd);
        check("lb_rdata_lit", rd, 32'hFFFFFF80);
        check("lb_stall_lit", st, 32'd4);
        run(1'b1, 1'b0, 9'h013, 3'd4, 32'd0, 32'h80FF7F01, 1, 2, st, er, rd);
        check("lbu_rdata_lit", rd, 32'h00000080);

        run(1'b0, 1'b1, 9'h022, 3'd1, 32'h0000ABCD, 32'd0, 2, 0, st, er, rd);
        check("sh_be_lit", {28'd0, snap_be}, 32'h0000000C);
        check("sh_wdata_lit", snap_wdata, 32'hABCDABCD);
        check("sh_addr_lit", {23'd0, snap_addr}, 32'h00000020);

        run(1'b1, 1'b0, 9'h005, 3'd2, 32'd0, 32'h11111111, 1, 1, st, er, rd);
        check("lw_mis_no_req", {31'd0, saw_req}, 32'd0);
        check("lw_mis_err_lit", {31'd0, er}, 32'd1);
        check("lw_mis_rdata_lit", rd, 32'd0);
        check("lw_mis_stall_lit", st, 32'd1);

        run(1'b0, 1'b1, 9'h017, 3'd0, 32'h0000005A, 32'd0, 3, 0, st, er, rd);
        check("sb_wdata_lit", snap_wdata, 32'h5A5A5A5A);
        run(1'b1, 1'b0, 9'h012, 3'd1, 32'd0, 32'h80017F02, 1, 1, st, er, rd);
        check("lh_rdata_lit", rd, 32'hFFFF8001);
        run(1'b1, 1'b0, 9'h010, 3'd5, 32'd0, 32'h80017F02, 1, 1, st, er, rd);
        run(1'b1, 1'b1, 9'h018, 3'd2, 32'h11223344, 32'h99999999, 1, 1, st, er, rd);
        check("rdwr_is_write", {31'd0, snap_we}, 32'd1);
        run(1'b1, 1'b0, 9'h020, 3'd3, 32'd0, 32'd0, 1, 1, st, er, rd);
        run(1'b0, 1'b1, 9'h011, 3'd1, 32'h0000BEEF, 32'd0, 1, 0, st, er, rd);

        run(1'b1, 1'b0, 9'h040, 3'd2, 32'd0, 32'h77777777, 0, 1, st, er, rd);
        check("tmo_stall_lit", st, 32'd17);
        bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        @(posedge clk); #1; @(posedge clk); #1;
        bus_rvalid = 1'b0;
        check("late_rvalid_ignored", mem_rdata, model_rdata);
        check("late_rvalid_no_stall", {31'd0, mem_stall}, 32'd0);

        run(1'b0, 1'b1, 9'h044, 3'd2, 32'hCAFE0001, 32'd0, 16, 0, st, er, rd);
        run(1'b1, 1'b0, 9'h048, 3'd2, 32'd0, 32'h55AA55AA, 1, 0, st, er, rd);
        run(1'b1, 1'b0, 9'h04C, 3'd2, 32'd0, 32'h0BADF00D, 1, 16, st, er, rd);
        check("rv_at_last_rdata_lit", rd, 32'h0BADF00D);

        set_expect(1'b0, 9'h030, 3'd2, 32'd0);
        mem_read = 1'b1; mem_addr = 9'h030; mem_funct3 = 3'd2; mem_wdata = 32'd0;
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_rdata = 32'd0;
        check("rst_mid_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_mid_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_mid_ctrl", {bus_we, mem_err, bus_be, 3'd0, bus_addr, 14'd0}, 32'd0);
        check("rst_mid_wdata", bus_wdata, 32'd0);
        check("rst_mid_rdata", mem_rdata, 32'd0);
        mem_read = 1'b0;
        @(negedge clk); reset = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        @(posedge clk); #1; @(posedge clk); #1;
        bus_rvalid = 1'b0;
        check("rst_late_rvalid", mem_rdata, model_rdata);
        run(1'b1, 1'b0, 9'h030, 3'd2, 32'd0, 32'hCAFEF00D, 1, 1, st, er, rd);
        check("post_rst_lw_lit", rd, 32'hCAFEF00D);
        check("post_rst_stall_lit", st, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
